array_output_drain: RTL and testbench

//  Downstream neighbour of the per-column output buffers of the systolic array.

---
 rtl/systola_pkg.sv | 22 ++
 rtl/drain_out_reg.sv | 46 ++++
 rtl/array_output_drain.sv | 103 ++++++++++
 tb/tb_array_output_drain.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systola_pkg.sv
// Shared definitions for the systolic array output path: default array geometry,
// the result word type and the drain sequencer state encoding.
package systola_pkg;

    localparam int ROWS_DEFAULT     = 8;
    localparam int COLS_DEFAULT     = 8;
    localparam int OUTWIDTH_DEFAULT = 32;

    typedef logic [OUTWIDTH_DEFAULT-1:0] res_t;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_DRAIN,
        DR_FLUSH
    } drain_state_e;

    // Index width that stays at least one bit for degenerate single-entry dimensions.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/drain_out_reg.sv
// One-entry valid/ready pipeline register holding a tagged result word.
// It can take a new word whenever it is empty or its current word leaves this cycle.
module drain_out_reg
    import systola_pkg::*;
#(
    parameter int DW = OUTWIDTH_DEFAULT,
    parameter int RW = 3,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] ld_data,
    input  logic [RW-1:0] ld_row,
    input  logic [CW-1:0] ld_col,
    input  logic          ld_last,
    input  logic          ready,
    output logic          can_load,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    assign can_load = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            row   <= '0;
            col   <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ld_data;
            row   <= ld_row;
            col   <= ld_col;
            last  <= ld_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/array_output_drain.sv
// Drains one finished tile from the per-column output buffers in column-major order
// and presents each word on a tagged valid/ready stream.
module array_output_drain
    import systola_pkg::*;
#(
    parameter int COLS     = COLS_DEFAULT,
    parameter int ROWS     = ROWS_DEFAULT,
    parameter int OUTWIDTH = OUTWIDTH_DEFAULT,
    localparam int RW      = idx_width(ROWS),
    localparam int CW      = idx_width(COLS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [COLS-1:0][OUTWIDTH-1:0] col_r,
    input  logic [COLS-1:0]               col_v,
    output logic [COLS-1:0]               col_rread,
    output logic [OUTWIDTH-1:0]           m_data,
    output logic [RW-1:0]                 m_row,
    output logic [CW-1:0]                 m_col,
    output logic                          m_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          busy,
    output logic                          tile_done
);

    drain_state_e  state;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] col_cnt;
    logic          can_load;
    logic          take;
    logic          last_word;

    assign last_word = (row_cnt == RW'(ROWS - 1)) && (col_cnt == CW'(COLS - 1));
    assign take      = (state == DR_DRAIN) && col_v[col_cnt] && can_load;
    assign busy      = (state != DR_IDLE);

    // The pop strobe is combinational so the buffer advances in the same cycle the word is captured.
    always_comb begin
        col_rread = '0;
        if (take) col_rread[col_cnt] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DR_IDLE;
            row_cnt   <= '0;
            col_cnt   <= '0;
            tile_done <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            case (state)
                DR_IDLE: begin
                    if (start) state <= DR_DRAIN;
                end
                DR_DRAIN: begin
                    if (take) begin
                        if (last_word) begin
                            state <= DR_FLUSH;
                        end else if (row_cnt == RW'(ROWS - 1)) begin
                            row_cnt <= '0;
                            col_cnt <= col_cnt + 1'b1;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                DR_FLUSH: begin
                    if (m_valid && m_ready) begin
                        state     <= DR_IDLE;
                        tile_done <= 1'b1;
                        row_cnt   <= '0;
                        col_cnt   <= '0;
                    end
                end
                default: state <= DR_IDLE;
            endcase
        end
    end

    drain_out_reg #(
        .DW (OUTWIDTH),
        .RW (RW),
        .CW (CW)
    ) u_out_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (take),
        .ld_data  (col_r[col_cnt]),
        .ld_row   (row_cnt),
        .ld_col   (col_cnt),
        .ld_last  (last_word),
        .ready    (m_ready),
        .can_load (can_load),
        .valid    (m_valid),
        .data     (m_data),
        .row      (m_row),
        .col      (m_col),
        .last     (m_last)
    );

endmodule

// File: tb/tb_array_output_drain.sv
// Bench for array_output_drain: column buffers are modelled as word arrays with read
// pointers, and the expected stream is derived from tile order and pop/accept counts.
module tb_array_output_drain;

    localparam int R = 8, C = 8, W = 32, TOTAL = R * C;
    localparam int SR = 4, SC = 2;

    logic clk = 1'b0;
    logic rst, start, m_ready;
    logic [C-1:0][W-1:0] col_r;
    logic [C-1:0] col_v, col_rread;
    logic [W-1:0] m_data;
    logic [2:0] m_row, m_col;
    logic m_last, m_valid, busy, tile_done;

    logic s_start, s_m_ready;
    logic [SC-1:0][W-1:0] s_col_r;
    logic [SC-1:0] s_col_v, s_col_rread;
    logic [W-1:0] s_m_data;
    logic [1:0] s_m_row;
    logic [0:0] s_m_col;
    logic s_m_last, s_m_valid, s_busy, s_tile_done;

    always #5 clk = ~clk;

    array_output_drain #(.COLS(C), .ROWS(R), .OUTWIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .col_r(col_r), .col_v(col_v),
        .col_rread(col_rread), .m_data(m_data), .m_row(m_row), .m_col(m_col),
        .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
        .tile_done(tile_done)
    );

    array_output_drain #(.COLS(SC), .ROWS(SR), .OUTWIDTH(W)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .col_r(s_col_r), .col_v(s_col_v),
        .col_rread(s_col_rread), .m_data(s_m_data), .m_row(s_m_row), .m_col(s_m_col),
        .m_last(s_m_last), .m_valid(s_m_valid), .m_ready(s_m_ready), .busy(s_busy),
        .tile_done(s_tile_done)
    );

    int errors = 0, checks = 0;

    logic [W-1:0] bufm [C][R];
    int ptr [C];
    logic [C-1:0] mask;

    bit active, done_pend;
    int pops, accs;

    logic [C-1:0] obs_rread, ex_rread;
    logic obs_valid, obs_last, obs_done, obs_busy;
    logic ex_valid, ex_last, ex_done, ex_busy;
    logic [W-1:0] obs_data, ex_data;
    logic [2:0] obs_row, obs_col, ex_row, ex_col;

    task automatic drive_cols();
        for (int c = 0; c < C; c++) begin
            col_v[c] = (ptr[c] < R) && !mask[c];
            col_r[c] = (ptr[c] < R) ? bufm[c][ptr[c]] : W'($urandom());
        end
    endtask

    task automatic fill(input bit ramp);
        for (int c = 0; c < C; c++) begin
            for (int r = 0; r < R; r++) bufm[c][r] = ramp ? W'(c * 16 + r) : W'($urandom());
            ptr[c] = 0;
        end
        drive_cols();
    endtask

    task automatic model_clear();
        active = 1'b0; done_pend = 1'b0; pops = 0; accs = 0;
    endtask

    // One clock: sample DUT and model expectation at negedge, then advance buffers and model.
    task automatic tick();
        int col;
        bit act0, hs, fin;
        @(negedge clk);
        obs_rread = col_rread; obs_valid = m_valid; obs_data = m_data;
        obs_row = m_row; obs_col = m_col; obs_last = m_last;
        obs_done = tile_done; obs_busy = busy;
        ex_valid = ((pops - accs) == 1);
        ex_busy = active;
        ex_done = done_pend;
        ex_rread = '0;
        col = pops / R;
        if (active && pops < TOTAL)
            if (col_v[col] && (!ex_valid || m_ready)) ex_rread[col] = 1'b1;
        if (accs < TOTAL) begin
            ex_data = bufm[accs / R][accs % R];
            ex_row = 3'(accs % R);
            ex_col = 3'(accs / R);
            ex_last = (accs == TOTAL - 1);
        end
        act0 = active;
        @(posedge clk);
        for (int c = 0; c < C; c++) if (obs_rread[c] && ptr[c] < R) ptr[c]++;
        hs = ex_valid && m_ready;
        fin = hs && (accs == TOTAL - 1);
        if (ex_rread != '0) pops++;
        if (hs) accs++;
        done_pend = fin;
        if (fin) begin active = 1'b0; pops = 0; accs = 0; end
        if (start && !act0) begin active = 1'b1; pops = 0; accs = 0; end
        #1 drive_cols();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m_ready = 1'b1; mask = '0;
        s_start = 1'b0; s_m_ready = 1'b1; s_col_v = '0; s_col_r = '0;
        model_clear();
        fill(1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({col_rread, m_valid, m_last, busy, tile_done, m_data, m_row, m_col} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%h v=%b l=%b b=%b d=%b data=%h row=%0d col=%0d exp all 0",
                     col_rread, m_valid, m_last, busy, tile_done, m_data, m_row, m_col);
        end
        rst = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 50 && accs < 5; n++) tick();
        checks++;
        if (accs != 5) begin errors++; $display("FAIL reset_pre_words got %0d exp 5", accs); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({col_rread, m_valid, m_last, busy, tile_done, m_data, m_row, m_col} !== '0) begin
            errors++;
            $display("FAIL reset_mid_drain got rd=%h v=%b l=%b b=%b d=%b data=%h row=%0d col=%0d exp all 0",
                     col_rread, m_valid, m_last, busy, tile_done, m_data, m_row, m_col);
        end
        model_clear();
        @(posedge clk); #1 rst = 1'b0;
        fill(1'b0);
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 200 && (active || done_pend); n++) begin
            tick();
            checks++;
            if ({obs_valid, obs_rread, obs_done, obs_busy} !== {ex_valid, ex_rread, ex_done, ex_busy}) begin
                errors++;
                $display("FAIL reset_ctrl t=%0t got v=%b rd=%h done=%b busy=%b exp v=%b rd=%h done=%b busy=%b",
                         $time, obs_valid, obs_rread, obs_done, obs_busy, ex_valid, ex_rread, ex_done, ex_busy);
            end
            if (ex_valid) begin
                checks++;
                if ({obs_data, obs_row, obs_col, obs_last} !== {ex_data, ex_row, ex_col, ex_last}) begin
                    errors++;
                    $display("FAIL reset_word got %h r%0d c%0d l%b exp %h r%0d c%0d l%b",
                             obs_data, obs_row, obs_col, obs_last, ex_data, ex_row, ex_col, ex_last);
                end
            end
        end
        checks++;
        if (active) begin errors++; $display("FAIL reset_timeout got active exp idle"); end
    endtask

    task automatic test_full_tile();
        int nhs, first_n, last_n, nlast;
        nhs = 0; first_n = -1; last_n = -1; nlast = 0;
        fill(1'b1); m_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 200 && (active || done_pend); n++) begin
            tick();
            if (obs_valid && m_ready) begin
                nhs++;
                if (first_n < 0) first_n = n;
                last_n = n;
                if (obs_last) nlast++;
            end
            checks++;
            if ({obs_valid, obs_rread, obs_done, obs_busy} !== {ex_valid, ex_rread, ex_done, ex_busy}) begin
                errors++;
                $display("FAIL full_ctrl t=%0t got v=%b rd=%h done=%b busy=%b exp v=%b rd=%h done=%b busy=%b",
                         $time, obs_valid, obs_rread, obs_done, obs_busy, ex_valid, ex_rread, ex_done, ex_busy);
            end
            if (ex_valid) begin
                checks++;
                if ({obs_data, obs_row, obs_col, obs_last} !== {ex_data, ex_row, ex_col, ex_last}) begin
                    errors++;
                    $display("FAIL full_word got %h r%0d c%0d l%b exp %h r%0d c%0d l%b",
                             obs_data, obs_row, obs_col, obs_last, ex_data, ex_row, ex_col, ex_last);
                end
            end
        end
        checks++;
        if (nhs != TOTAL || last_n - first_n != TOTAL - 1 || nlast != 1) begin
            errors++;
            $display("FAIL full_throughput got words=%0d span=%0d lasts=%0d exp %0d %0d 1",
                     nhs, last_n - first_n, nlast, TOTAL, TOTAL - 1);
        end
    endtask

    task automatic test_backpressure();
        int nhs;
        logic [W-1:0] prev_data;
        logic [2:0] prev_row, prev_col;
        logic prev_last, prev_stall;
        nhs = 0; prev_stall = 1'b0;
        prev_data = '0; prev_row = '0; prev_col = '0; prev_last = 1'b0;
        fill(1'b0);
        start = 1'b1; m_ready = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 400 && (active || done_pend); n++) begin
            m_ready = (n >= 20 && n <= 22) ? 1'b0 : ($urandom_range(0, 3) != 0);
            tick();
            if (obs_valid && m_ready) nhs++;
            checks++;
            if ({obs_valid, obs_rread, obs_done, obs_busy} !== {ex_valid, ex_rread, ex_done, ex_busy}) begin
                errors++;
                $display("FAIL bp_ctrl t=%0t got v=%b rd=%h done=%b busy=%b exp v=%b rd=%h done=%b busy=%b",
                         $time, obs_valid, obs_rread, obs_done, obs_busy, ex_valid, ex_rread, ex_done, ex_busy);
            end
            if (ex_valid) begin
                checks++;
                if ({obs_data, obs_row, obs_col, obs_last} !== {ex_data, ex_row, ex_col, ex_last}) begin
                    errors++;
                    $display("FAIL bp_word got %h r%0d c%0d l%b exp %h r%0d c%0d l%b",
                             obs_data, obs_row, obs_col, obs_last, ex_data, ex_row, ex_col, ex_last);
                end
            end
            if (prev_stall) begin
                checks++;
                if ({obs_data, obs_row, obs_col, obs_last} !== {prev_data, prev_row, prev_col, prev_last}) begin
                    errors++;
                    $display("FAIL bp_hold got %h r%0d c%0d exp %h r%0d c%0d",
                             obs_data, obs_row, obs_col, prev_data, prev_row, prev_col);
                end
            end
            if (obs_valid && !m_ready) begin
                checks++;
                if (obs_rread !== '0) begin
                    errors++;
                    $display("FAIL bp_no_pop got rd=%h exp 0", obs_rread);
                end
            end
            prev_stall = obs_valid && !m_ready;
            prev_data = obs_data; prev_row = obs_row; prev_col = obs_col; prev_last = obs_last;
        end
        checks++;
        if (nhs != TOTAL || active) begin
            errors++;
            $display("FAIL bp_count got words=%0d active=%b exp %0d idle", nhs, active, TOTAL);
        end
        m_ready = 1'b1;
    endtask

    task automatic test_starvation();
        int left;
        bit starved, resumed;
        left = 0; starved = 1'b0; resumed = 1'b0;
        fill(1'b0); m_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 300 && (active || done_pend); n++) begin
            tick();
            checks++;
            if ({obs_valid, obs_rread, obs_done, obs_busy} !== {ex_valid, ex_rread, ex_done, ex_busy}) begin
                errors++;
                $display("FAIL starve_ctrl t=%0t got v=%b rd=%h done=%b busy=%b exp v=%b rd=%h done=%b busy=%b",
                         $time, obs_valid, obs_rread, obs_done, obs_busy, ex_valid, ex_rread, ex_done, ex_busy);
            end
            if (ex_valid) begin
                checks++;
                if ({obs_data, obs_row, obs_col, obs_last} !== {ex_data, ex_row, ex_col, ex_last}) begin
                    errors++;
                    $display("FAIL starve_word got %h r%0d c%0d l%b exp %h r%0d c%0d l%b",
                             obs_data, obs_row, obs_col, obs_last, ex_data, ex_row, ex_col, ex_last);
                end
            end
            if (left > 0) begin
                checks++;
                if (obs_rread !== '0) begin
                    errors++;
                    $display("FAIL starve_no_pop got rd=%h exp 0", obs_rread);
                end
                left--;
                if (left == 0) begin mask[2] = 1'b0; resumed = 1'b1; end
            end else if (resumed && obs_rread != '0) begin
                checks++;
                if (obs_rread !== 8'h04 || ptr[3] != 0) begin
                    errors++;
                    $display("FAIL starve_resume got rd=%h col3_ptr=%0d exp 04 0", obs_rread, ptr[3]);
                end
                resumed = 1'b0;
            end
            if (!starved && pops == 2 * R + 3) begin
                mask[2] = 1'b1; left = 10; starved = 1'b1;
            end
            drive_cols();
        end
        checks++;
        if (active || !starved) begin
            errors++;
            $display("FAIL starve_done got active=%b starved=%b exp 0 1", active, starved);
        end
        mask = '0;
    endtask

    task automatic test_back_to_back();
        int nhs, ndone;
        bit restarted;
        nhs = 0; ndone = 0; restarted = 1'b0;
        fill(1'b0); m_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 400 && (active || done_pend); n++) begin
            start = (n == 10);
            if (done_pend && !restarted) begin
                start = 1'b1; restarted = 1'b1; fill(1'b0);
            end
            tick();
            start = 1'b0;
            if (obs_valid && m_ready) nhs++;
            if (obs_done) ndone++;
            checks++;
            if ({obs_valid, obs_rread, obs_done, obs_busy} !== {ex_valid, ex_rread, ex_done, ex_busy}) begin
                errors++;
                $display("FAIL b2b_ctrl t=%0t got v=%b rd=%h done=%b busy=%b exp v=%b rd=%h done=%b busy=%b",
                         $time, obs_valid, obs_rread, obs_done, obs_busy, ex_valid, ex_rread, ex_done, ex_busy);
            end
            if (ex_valid) begin
                checks++;
                if ({obs_data, obs_row, obs_col, obs_last} !== {ex_data, ex_row, ex_col, ex_last}) begin
                    errors++;
                    $display("FAIL b2b_word got %h r%0d c%0d l%b exp %h r%0d c%0d l%b",
                             obs_data, obs_row, obs_col, obs_last, ex_data, ex_row, ex_col, ex_last);
                end
            end
        end
        checks++;
        if (nhs != 2 * TOTAL || ndone != 2 || active) begin
            errors++;
            $display("FAIL b2b_count got words=%0d dones=%0d exp %0d 2", nhs, ndone, 2 * TOTAL);
        end
    endtask

    task automatic test_small_build();
        int sptr [SC];
        int words, ndone;
        logic [W-1:0] exp_d;
        words = 0; ndone = 0;
        for (int c = 0; c < SC; c++) sptr[c] = 0;
        s_m_ready = 1'b1;
        for (int c = 0; c < SC; c++) begin s_col_v[c] = 1'b1; s_col_r[c] = W'(c * 16); end
        s_start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (s_m_valid && s_m_ready) begin
                exp_d = W'((words / SR) * 16 + (words % SR));
                words++;
                checks++;
                if (s_m_data !== exp_d || s_m_row !== 2'(SR == 0 ? 0 : (words - 1) % SR) ||
                    s_m_col !== 1'((words - 1) / SR) || s_m_last !== (words == SR * SC)) begin
                    errors++;
                    $display("FAIL small_word got %h r%0d c%0d l%b exp %h word %0d",
                             s_m_data, s_m_row, s_m_col, s_m_last, exp_d, words);
                end
            end
            if (s_tile_done) ndone++;
            for (int c = 0; c < SC; c++) if (s_col_rread[c]) sptr[c]++;
            @(posedge clk);
            #1 s_start = 1'b0;
            for (int c = 0; c < SC; c++) begin
                s_col_v[c] = (sptr[c] < SR);
                s_col_r[c] = W'(c * 16 + sptr[c]);
            end
        end
        checks++;
        if (words != SR * SC || ndone != 1 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL small_count got words=%0d dones=%0d busy=%b exp %0d 1 0",
                     words, ndone, s_busy, SR * SC);
        end
    endtask

    initial begin
        test_reset();
        test_full_tile();
        test_backpressure();
        test_starvation();
        test_back_to_back();
        test_small_build();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
